// File: rtl/mult_pkg.sv
// Shared constants for the sequential shift-add multiplier: FSM state
// encoding, default operand width and counter sizing.
package mult_pkg;

  // FSM state encoding (2-bit, fixed so downstream debug probes decode it).
  localparam logic [1:0] ESTADO_IDLE = 2'b00;
  localparam logic [1:0] ESTADO_BUSY = 2'b01;
  localparam logic [1:0] ESTADO_DONE = 2'b10;
  localparam logic [1:0] ESTADO_FIX  = 2'b11;

  // Default operand width; each result half has this many bits.
  localparam int WIDTH_DEF = 16;

  // Iteration counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage : mult_pkg

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One partial-product step per clock; fixed latency of WIDTH steps.
// Results are held in output registers that change only on entry to DONE,
// so the downstream result-select mux may sample them at any time.
// Optional build macro MULT_SEQ_SIGNED_EN: two's complement operands,
// handled as magnitudes plus a sign bit, with a FIX state that negates the
// product when required (one extra cycle of latency).
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operando_a,
  input  logic [WIDTH-1:0] operando_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado_lo,
  output logic [WIDTH-1:0] resultado_hi
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]         estado;
  logic [WIDTH-1:0]   mcand;      // multiplicand (magnitude in signed builds)
  logic [WIDTH-1:0]   mplier;     // multiplier, consumed LSB first
  logic [2*WIDTH-1:0] acc;        // running product
  logic [CW-1:0]      contador;   // remaining iterations

  logic [WIDTH:0]     soma;       // upper half + partial product, with carry
  logic [2*WIDTH:0]   acc_ext;    // {carry, accumulator} before the shift
  logic [2*WIDTH-1:0] acc_passo;  // accumulator after one iteration
  logic [WIDTH-1:0]   cap_a;      // operand values as they will be captured
  logic [WIDTH-1:0]   cap_b;

`ifdef MULT_SEQ_SIGNED_EN
  logic               sinal;      // product sign recorded at capture
  logic               sinal_cap;
  logic [2*WIDTH-1:0] acc_fix;    // sign-corrected final product
`endif

  // One shift-add iteration: conditional add into the upper half, then a
  // right shift of the carry-extended accumulator.
  // NOTE: every variable assigned in always_comb receives a value on every
  // path (here unconditionally), otherwise a latch would be inferred.
  always_comb begin
    soma      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    acc_ext   = {soma, acc[WIDTH-1:0]};
    acc_passo = (2*WIDTH)'(acc_ext >> 1);
  end

`ifdef MULT_SEQ_SIGNED_EN
  // Signed capture: magnitudes go to the datapath, sign is kept aside.
  // The magnitude of the most negative value wraps to itself, which read as
  // unsigned is exactly 2^(WIDTH-1), so no special case is required.
  always_comb begin
    cap_a     = operando_a[WIDTH-1] ? (~operando_a + 1'b1) : operando_a;
    cap_b     = operando_b[WIDTH-1] ? (~operando_b + 1'b1) : operando_b;
    sinal_cap = operando_a[WIDTH-1] ^ operando_b[WIDTH-1];
    acc_fix   = sinal ? (~acc + 1'b1) : acc;
  end
`else
  // Unsigned capture: operands enter the datapath unchanged.
  always_comb begin
    cap_a = operando_a;
    cap_b = operando_b;
  end
`endif

  // Status outputs decode the registered state, so they are glitch-free.
  always_comb begin
    busy = (estado == ESTADO_BUSY) || (estado == ESTADO_FIX);
    done = (estado == ESTADO_DONE);
  end

  // FSM and datapath registers. IDLE and DONE both accept a new request,
  // which gives back-to-back operation with no idle bubble.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= ESTADO_IDLE;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      contador     <= '0;
      resultado_lo <= '0;
      resultado_hi <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      sinal        <= 1'b0;
`endif
    end else begin
      case (estado)
        ESTADO_IDLE, ESTADO_DONE: begin
          if (start) begin
            mcand    <= cap_a;
            mplier   <= cap_b;
            acc      <= '0;
            contador <= CW'(WIDTH);
            estado   <= ESTADO_BUSY;
`ifdef MULT_SEQ_SIGNED_EN
            sinal    <= sinal_cap;
`endif
          end else begin
            estado <= ESTADO_IDLE;
          end
        end

        ESTADO_BUSY: begin
          acc      <= acc_passo;
          mplier   <= mplier >> 1;
          contador <= contador - 1'b1;
          // Last iteration: the counter reaches zero on this edge.
          if (contador == CW'(1)) begin
`ifdef MULT_SEQ_SIGNED_EN
            estado <= ESTADO_FIX;
`else
            estado       <= ESTADO_DONE;
            resultado_lo <= acc_passo[WIDTH-1:0];
            resultado_hi <= acc_passo[2*WIDTH-1:WIDTH];
`endif
          end
        end

`ifdef MULT_SEQ_SIGNED_EN
        ESTADO_FIX: begin
          estado       <= ESTADO_DONE;
          resultado_lo <= acc_fix[WIDTH-1:0];
          resultado_hi <= acc_fix[2*WIDTH-1:WIDTH];
        end
`endif

        default: estado <= ESTADO_IDLE;
      endcase
    end
  end

endmodule : mult_seq

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq (WIDTH=16). Products are predicted with
// plain integer multiplication; cycle latency and handshake behaviour are
// predicted from the protocol rules. Honours MULT_SEQ_SIGNED_EN when defined.
module tb_mult_seq;

  localparam int W     = 16;
  localparam int LIMIT = 100;
`ifdef MULT_SEQ_SIGNED_EN
  localparam int LAT = 18;  // cycle (after the accept edge) in which done is high
`else
  localparam int LAT = 17;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  operando_a = '0;
  logic [W-1:0]  operando_b = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  resultado_lo;
  logic [W-1:0]  resultado_hi;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   prev  = '0;   // last product the outputs should be holding

  mult_seq #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .operando_a   (operando_a),
    .operando_b   (operando_b),
    .busy         (busy),
    .done         (done),
    .resultado_lo (resultado_lo),
    .resultado_hi (resultado_hi)
  );

  always #5 clock = ~clock;

  // Reference product.
  function automatic logic [31:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SEQ_SIGNED_EN
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p;
`else
    return {16'h0, a} * {16'h0, b};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; requests an operation and returns at the negedge of
  // the first cycle after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start      = 1'b1;
    operando_a = a;
    operando_b = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Waits for done, counting cycles from the accept edge. Optionally pulses
  // start again in cycle poke_cyc (must be ignored). Returns at the negedge
  // of the done cycle.
  task automatic wait_done(input string tag, input logic [31:0] exp, input int poke_cyc,
                           input logic [W-1:0] pa, input logic [W-1:0] pb);
    int n   = 1;
    int bsy = 0;
    while (!done && n < LIMIT) begin
      if (busy) bsy++;
      if (n == 3) check({tag, " held during busy"}, {resultado_hi, resultado_lo}, prev);
      if (n == poke_cyc) begin
        start = 1'b1; operando_a = pa; operando_b = pb;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, n, LAT);
    check({tag, " busy cycles"}, bsy, LAT - 1);
    check({tag, " busy low at done"}, {31'b0, busy}, 0);
    check({tag, " product"}, {resultado_hi, resultado_lo}, exp);
    prev = exp;
  endtask

  // After a done cycle with no new request: pulse ends, result stays.
  task automatic after_done(input string tag);
    @(negedge clock);
    check({tag, " done one cycle"}, {31'b0, done}, 0);
    check({tag, " result held"}, {resultado_hi, resultado_lo}, prev);
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(a, b);
    wait_done(tag, ref_mul(a, b), -1, '0, '0);
    after_done(tag);
  endtask

  initial begin
    int nz;
    int seen;
    logic [W-1:0] ra, rb;

    // Reset and idle.
    repeat (3) @(negedge clock);
    check("reset busy", {31'b0, busy}, 0);
    check("reset done", {31'b0, done}, 0);
    check("reset result", {resultado_hi, resultado_lo}, 0);
    reset = 1'b1;
    nz = 0;
    repeat (5) begin
      @(negedge clock);
      if (busy || done || resultado_hi != 0 || resultado_lo != 0) nz++;
    end
    check("idle stays zero", nz, 0);

    // Directed cases.
    full_op("3x5", 16'd3, 16'd5);
    full_op("ffffxffff", 16'hFFFF, 16'hFFFF);
    full_op("0x1234", 16'h0000, 16'h1234);
    full_op("fffdx5", 16'hFFFD, 16'd5);
    full_op("8000x8000", 16'h8000, 16'h8000);
    full_op("8000xffff", 16'h8000, 16'hFFFF);

    // Start while busy is ignored; then back-to-back with start in DONE.
    start_op(16'd7, 16'd9);
    wait_done("7x9 poke", ref_mul(16'd7, 16'd9), 5, 16'd2, 16'd2);
    start_op(16'd10, 16'd10);
    check("b2b busy no bubble", {31'b0, busy}, 1);
    wait_done("b2b 10x10", ref_mul(16'd10, 16'd10), -1, '0, '0);
    after_done("b2b 10x10");

    // Reset in the middle of an operation.
    start_op(16'd100, 16'd100);
    repeat (7) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 0);
    check("abort done", {31'b0, done}, 0);
    check("abort result", {resultado_hi, resultado_lo}, 0);
    @(negedge clock);
    reset = 1'b1;
    prev  = '0;
    seen  = 0;
    repeat (25) begin
      @(negedge clock);
      if (done) seen++;
    end
    check("abort no done", seen, 0);
    full_op("after abort 100x100", 16'd100, 16'd100);

    // Randomized operands against the reference product.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      full_op($sformatf("rand%0d", i), ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mult_seq
